// File: rtl/vpu_result_drain_pkg.sv
// Shared types and width helpers for the vector-unit result drain.
// This package holds the drain FSM encoding and the widths derived from the parameters.
package vpu_result_drain_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  localparam int unsigned ROWS_DRAINED_W = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vpu_row_fifo.sv
// Synchronous row FIFO with a combinational head and a count that spans 0..DEPTH.
// The caller qualifies push and pop, so a push while full only arrives together with a pop.
module vpu_row_fifo
  import vpu_result_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/vpu_result_drain.sv
// Captures result rows strobed out of the vector unit into a row FIFO and serializes
// them lane by lane onto a valid/ready element stream, flagging rows lost to overflow.
module vpu_result_drain
  import vpu_result_drain_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned ROW_A      = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 deload_out,
  input  logic [ADDR_WIDTH-1:0]                addr_res,
  input  logic [OUT_WIDTH*ROW_A-1:0]           out,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [OUT_WIDTH-1:0]                 m_data,
  output logic [ADDR_WIDTH+idx_w(ROW_A)-1:0]   m_addr,
  output logic                                 m_last,
  output logic                                 almost_full,
  output logic                                 overflow,
  output logic [ROWS_DRAINED_W-1:0]            rows_drained
);

  localparam int unsigned LANE_W  = idx_w(ROW_A);
  localparam int unsigned ROW_W   = OUT_WIDTH * ROW_A;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + ROW_W;
  localparam int unsigned CNT_W   = cnt_w(FIFO_DEPTH);

  drain_state_e              state_q, state_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [ROWS_DRAINED_W-1:0] rows_drained_q, rows_drained_d;
  logic                      almost_full_q, almost_full_d;
  logic                      overflow_q, overflow_d;

  logic [ENTRY_W-1:0]    fifo_din;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      count_next;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [ROW_W-1:0]      head_row;
  logic [OUT_WIDTH-1:0]  lane_data;
  logic                  streaming;
  logic                  handshake;
  logic                  at_last_lane;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  assign fifo_din  = {addr_res, out};
  assign head_addr = fifo_dout[ENTRY_W-1 -: ADDR_WIDTH];
  assign head_row  = fifo_dout[ROW_W-1:0];

  assign streaming    = (state_q == ST_STREAM);
  assign handshake    = streaming && m_ready;
  assign at_last_lane = (lane_q == LANE_W'(ROW_A - 1));
  assign pop          = handshake && at_last_lane;
  // A full FIFO still takes the row when the head retires in the same cycle.
  assign push_ok      = deload_out && (!fifo_full || pop);
  assign drop         = deload_out && !push_ok;

  vpu_row_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    count_next = fifo_count;
    if (push_ok && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    rows_drained_d = rows_drained_q;
    almost_full_d  = (count_next >= CNT_W'(FIFO_DEPTH - 1));
    overflow_d     = overflow_q || drop;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (handshake) begin
          if (at_last_lane) begin
            lane_d         = '0;
            rows_drained_d = rows_drained_q + ROWS_DRAINED_W'(1);
            if (count_next == '0) begin
              state_d = ST_IDLE;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      lane_q         <= '0;
      rows_drained_q <= '0;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      rows_drained_q <= rows_drained_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < int'(ROW_A); i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_data = head_row[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // ROW_A is a power of two, so row_addr*ROW_A + lane is a plain concatenation.
  assign m_valid      = streaming;
  assign m_data       = streaming ? lane_data : '0;
  assign m_addr       = streaming ? {head_addr, lane_q} : '0;
  assign m_last       = streaming && at_last_lane;
  assign almost_full  = almost_full_q;
  assign overflow     = overflow_q;
  assign rows_drained = rows_drained_q;

endmodule

// File: doc/vpu_result_drain.md
# vpu_result_drain

Downstream stage of the tiled vector unit. It captures each result row that the unit presents on `out` when `deload_out` pulses, and buffers it in a small row FIFO. It then serializes the row lane by lane onto a valid/ready element stream for the host or a result collector. The unit has no backpressure path, so the block raises `almost_full` and latches a sticky `overflow` flag when a row is lost.

## Interface
Parameters (defaults match config_sys.vh):
- `OUT_WIDTH`, 16, width of one result lane
- `ROW_A`, 4, lanes per result row; power of two
- `ADDR_WIDTH`, 8, width of `addr_res`
- `FIFO_DEPTH`, 4, row entries buffered; power of two, ≥2

Ports:
- `clk`  input  1  the block's single clock
- `reset`  input  1  asynchronous, active-low reset
- `deload_out`  input  1  one-cycle strobe: `out`/`addr_res` hold a valid row
- `addr_res`  input  ADDR_WIDTH  row address of the presented row
- `out`  input  OUT_WIDTH*ROW_A  result row; lane 0 = bits [OUT_WIDTH-1:0]
- `m_valid`  output  1  element available
- `m_ready`  input  1  consumer accepts element
- `m_data`  output  OUT_WIDTH  current element
- `m_addr`  output  ADDR_WIDTH+clog2(ROW_A)  element address = row_addr*ROW_A + lane
- `m_last`  output  1  element is lane ROW_A-1 of its row
- `almost_full`  output  1  FIFO count ≥ FIFO_DEPTH-1
- `overflow`  output  1  sticky: a row was dropped
- `rows_drained`  output  16  count of rows fully streamed; wraps modulo 2^16

## Operation
- Push:
  - `deload_out`=1 writes {`addr_res`, `out`} into the FIFO tail.
  - The push is accepted if count < FIFO_DEPTH, or if a pop completes in the same cycle (full with simultaneous pop is accepted).
  - Otherwise the row is dropped and `overflow` is set. Only reset clears `overflow`.
- State machine:
  - IDLE: FIFO empty, `m_valid`=0. Moves to STREAM on the cycle after count becomes nonzero.
  - STREAM: `m_valid`=1. The lane counter selects lane `lane` of the head row.
  - A handshake (`m_valid`&`m_ready`) advances `lane`.
  - On a handshake with `m_last`=1, the head is popped, `lane` resets to 0 and `rows_drained` increments.
  - The block then stays in STREAM if another row remains, otherwise it returns to IDLE.
- `m_data`, `m_addr` and `m_last` are 0 when `m_valid`=0. They hold stable while `m_valid`=1 and `m_ready`=0.
- `m_addr` is zero-extended arithmetic with no overflow. Row address 255 with ROW_A=4 gives 1020..1023.
- FIFO pointers wrap modulo FIFO_DEPTH. Count runs 0..FIFO_DEPTH, with a separate full/empty distinction.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears:
  - state = IDLE, `lane`=0, FIFO count/pointers=0
  - `m_valid`=0, `m_data`=0, `m_addr`=0, `m_last`=0, `almost_full`=0, `overflow`=0, `rows_drained`=0
- Reset asserted mid-row discards all buffered data. The next element is emitted only after a new push.
- Latency:
  - A push at edge t gives `m_valid`=1 after edge t+1, so the first lane is visible the cycle after the capture cycle.
  - With `m_ready` held high, one row streams in ROW_A cycles. Back-to-back rows stream with no bubble.
- `almost_full` and `overflow` are registered and update on the edge following the causing push.
- Throughput: sustained one row per ROW_A cycles. Bursts of `deload_out` beyond that rate consume FIFO slack.

## Structure
- Lane width, lane count and address width come from config_sys.vh. No further shared typedefs are needed.
- One sub-module, `vpu_row_fifo`: a synchronous FIFO with parameterized width (ADDR_WIDTH+OUT_WIDTH*ROW_A) and depth.
  - Ports: push, pop, din, dout (head, combinational), count, full, empty.
- The top level holds the IDLE/STREAM FSM, the lane counter, the lane mux, the address computation, the flags and `rows_drained`.

## Test plan
- Single row: `addr_res`=5, `out`=0x0004_0003_0002_0001, `m_ready`=1.
  - Expect 4 elements data 1,2,3,4 and addr 20,21,22,23.
  - `m_last` is high only on data 4; `rows_drained`=1. `m_valid` first rises the cycle after the strobe.
- Backpressure: same row with `m_ready` toggled 1,0,0,1,1,0,1.
  - Data and address stay stable while stalled. Exactly 4 handshakes occur, in order 1..4.
- Fill/overflow: `m_ready`=0 and 5 strobes with rows A..E.
  - `almost_full`=1 after the 3rd push and `overflow`=1 after the 5th; E is dropped.
  - Releasing `m_ready` streams A..D only; `rows_drained`=4.
- Full with simultaneous pop: FIFO full and head on lane 3 with `m_ready`=1, strobe new row F in the same cycle.
  - F is accepted, `overflow` stays 0, and F streams last.
- Reset mid-row: assert `reset`=0 after 2 of 4 lanes.
  - All outputs are 0 immediately. After release, no elements appear until a new strobe; the new row streams from lane 0.
